// File: rtl/fb_swap_pkg.sv
// fb_swap_ctrl shared types and constants.
// Flip FSM states, burst alignment and default buffer bases.
package fb_swap_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PENDING   = 2'd1,
    WAIT_DROP = 2'd2
  } swap_state_t;

  localparam int unsigned BURST_ALIGN_BITS = 6;

  function automatic longint unsigned fb0_base_default();
    return 64'd0;
  endfunction

  function automatic longint unsigned fb1_base_default(
    input int unsigned hdisp,
    input int unsigned vdisp
  );
    return 64'(4) * 64'(hdisp) * 64'(vdisp);
  endfunction

endpackage

// File: rtl/fb_underrun_mon.sv
// Pixel FIFO underrun monitor.
// Saturating event counter plus sticky flag; clear wins.
module fb_underrun_mon #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             pixel_clk,
  input  logic             pixel_rst,
  input  logic             fifo_read,
  input  logic             fifo_rempty,
  input  logic             underrun_clr,
  output logic [CNT_W-1:0] underrun_cnt,
  output logic             underrun_flag
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             event_w;

  assign event_w = fifo_read & fifo_rempty;

  // next count/flag: clear beats a same-cycle event
  always_comb begin
    cnt_d  = cnt_q;
    flag_d = flag_q;
    if (underrun_clr) begin
      cnt_d  = '0;
      flag_d = 1'b0;
    end else if (event_w) begin
      flag_d = 1'b1;
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // stats registers
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end

  assign underrun_cnt  = cnt_q;
  assign underrun_flag = flag_q;

endmodule

// File: rtl/fb_swap_ctrl.sv
// Page-flip scheduler: commits swaps only on vsync fall.
// Optional FIFO underrun stats under FB_SWAP_UNDERRUN_EN.
module fb_swap_ctrl
  import fb_swap_pkg::*;
#(
  parameter int unsigned     HDISP    = 800,
  parameter int unsigned     VDISP    = 480,
  parameter int unsigned     ADDR_W   = 32,
  parameter longint unsigned FB0_BASE = fb0_base_default(),
  parameter longint unsigned FB1_BASE = fb1_base_default(HDISP, VDISP),
  parameter int unsigned     CNT_W    = 16
) (
  input  logic              pixel_clk,
  input  logic              pixel_rst,
  input  logic              vs,
  input  logic              swap_req,
  input  logic [ADDR_W-1:0] swap_base,
  output logic              swap_ack,
  output logic [ADDR_W-1:0] front_base,
  output logic [ADDR_W-1:0] back_base,
  output logic              swap_pending,
  output logic [CNT_W-1:0]  frame_cnt,
  input  logic              fifo_read,
  input  logic              fifo_rempty,
  input  logic              underrun_clr,
  output logic [CNT_W-1:0]  underrun_cnt,
  output logic              underrun_flag
);

  localparam logic [ADDR_W-1:0] FB0_RST = ADDR_W'(FB0_BASE);
  localparam logic [ADDR_W-1:0] FB1_RST = ADDR_W'(FB1_BASE);
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ADDR_W'((64'd1 << BURST_ALIGN_BITS) - 64'd1);

  swap_state_t       state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] front_q, front_d;
  logic [ADDR_W-1:0] back_q, back_d;
  logic              ack_q, ack_d;
  logic              pend_q, pend_d;
  logic [CNT_W-1:0]  frame_q, frame_d;
  logic              vs_q;
  logic              vs_fall;

  assign vs_fall = vs_q & ~vs;

  // flip FSM next state, commit and frame count
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    front_d = front_q;
    back_d  = back_q;
    ack_d   = 1'b0;
    frame_d = frame_q;
    unique case (state_q)
      IDLE: begin
        if (swap_req) begin
          base_d  = swap_base & ~ALIGN_MASK;
          state_d = PENDING;
        end
      end
      PENDING: begin
        if (vs_fall) begin
          front_d = base_q;
          back_d  = front_q;
          ack_d   = 1'b1;
          state_d = WAIT_DROP;
        end
      end
      WAIT_DROP: begin
        if (!swap_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (vs_fall) begin
      frame_d = frame_q + CNT_W'(1);
    end
    pend_d = (state_d == PENDING);
  end

  // state and output registers
  always_ff @(posedge pixel_clk or posedge pixel_rst) begin
    if (pixel_rst) begin
      state_q <= IDLE;
      base_q  <= '0;
      front_q <= FB0_RST;
      back_q  <= FB1_RST;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      frame_q <= '0;
      vs_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      front_q <= front_d;
      back_q  <= back_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      vs_q    <= vs;
    end
  end

  assign swap_ack     = ack_q;
  assign front_base   = front_q;
  assign back_base    = back_q;
  assign swap_pending = pend_q;
  assign frame_cnt    = frame_q;

`ifdef FB_SWAP_UNDERRUN_EN
  fb_underrun_mon #(
    .CNT_W(CNT_W)
  ) u_mon (
    .pixel_clk    (pixel_clk),
    .pixel_rst    (pixel_rst),
    .fifo_read    (fifo_read),
    .fifo_rempty  (fifo_rempty),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt),
    .underrun_flag(underrun_flag)
  );
`else
  logic unused_fifo;
  assign unused_fifo   = ^{fifo_read, fifo_rempty, underrun_clr};
  assign underrun_cnt  = '0;
  assign underrun_flag = 1'b0;
`endif

endmodule

// File: tb/tb_fb_swap_ctrl.sv
// Directed bench for fb_swap_ctrl with short synthetic frames.
// Commits are checked through a queue of expected base pairs.
module tb_fb_swap_ctrl;

  localparam int FRAME = 40;
  localparam logic [31:0] FB1 = 32'd1536000;

  logic        pixel_clk;
  logic        pixel_rst;
  logic        vs;
  logic        swap_req;
  logic [31:0] swap_base;
  logic        swap_ack;
  logic [31:0] front_base;
  logic [31:0] back_base;
  logic        swap_pending;
  logic [3:0]  frame_cnt;
  logic        fifo_read;
  logic        fifo_rempty;
  logic        underrun_clr;
  logic [3:0]  underrun_cnt;
  logic        underrun_flag;

  fb_swap_ctrl #(
    .CNT_W(4)
  ) dut (
    .pixel_clk    (pixel_clk),
    .pixel_rst    (pixel_rst),
    .vs           (vs),
    .swap_req     (swap_req),
    .swap_base    (swap_base),
    .swap_ack     (swap_ack),
    .front_base   (front_base),
    .back_base    (back_base),
    .swap_pending (swap_pending),
    .frame_cnt    (frame_cnt),
    .fifo_read    (fifo_read),
    .fifo_rempty  (fifo_rempty),
    .underrun_clr (underrun_clr),
    .underrun_cnt (underrun_cnt),
    .underrun_flag(underrun_flag)
  );

  initial begin
    pixel_clk = 1'b0;
    forever #5 pixel_clk = ~pixel_clk;
  end

  int total = 0;
  int bad   = 0;
  int acks  = 0;
  int pos   = 0;

  int          m_st;
  logic        m_vsq;
  logic        m_ack;
  logic [31:0] m_lat;
  logic [31:0] m_front;
  logic [31:0] m_back;
  logic [3:0]  m_frame;
  logic [3:0]  m_ucnt;
  logic        m_uflag;
  logic [63:0] sbq[$];

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st    = 0;
    m_vsq   = 1'b1;
    m_ack   = 1'b0;
    m_lat   = '0;
    m_front = '0;
    m_back  = FB1;
    m_frame = '0;
    m_ucnt  = '0;
    m_uflag = 1'b0;
    sbq.delete();
  endtask

  task automatic tick();
    logic        fall;
    logic [63:0] e;
    @(posedge pixel_clk);
    #1;
    if (!pixel_rst) begin
      fall  = m_vsq & ~vs;
      m_vsq = vs;
      m_ack = 1'b0;
      case (m_st)
        0: if (swap_req) begin
          m_lat = swap_base & ~32'h3f;
          sbq.push_back({m_lat, m_front});
          m_st = 1;
        end
        1: if (fall) begin
          m_ack   = 1'b1;
          m_back  = m_front;
          m_front = m_lat;
          m_st    = 2;
        end
        default: if (!swap_req) m_st = 0;
      endcase
      if (fall) m_frame = m_frame + 4'd1;
`ifdef FB_SWAP_UNDERRUN_EN
      if (underrun_clr) begin
        m_ucnt  = '0;
        m_uflag = 1'b0;
      end else if (fifo_read && fifo_rempty) begin
        m_uflag = 1'b1;
        if (m_ucnt != 4'hf) m_ucnt = m_ucnt + 4'd1;
      end
`endif
      chk("ack", swap_ack, m_ack);
      chk("pending", swap_pending, m_st == 1);
      chk("frame_cnt", frame_cnt, m_frame);
      chk("ucnt", underrun_cnt, m_ucnt);
      chk("uflag", underrun_flag, m_uflag);
      if (swap_ack === 1'b1) begin
        acks++;
        chk("sb_nonempty", sbq.size() != 0, 1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("front_commit", front_base, e[63:32]);
          chk("back_commit", back_base, e[31:0]);
        end
      end
    end
    pos = (pos + 1) % FRAME;
    vs  = (pos >= FRAME - 3) ? 1'b0 : 1'b1;
  endtask

  task automatic wait_ack(input int lim, output int n);
    int a0;
    a0 = acks;
    n  = 0;
    while (acks == a0 && n < lim) begin
      tick();
      n++;
    end
    chk("ack_seen", acks != a0, 1);
  endtask

  int n;
  int a0;
  logic [3:0] f0;

  initial begin
    pixel_rst    = 1'b1;
    vs           = 1'b1;
    swap_req     = 1'b0;
    swap_base    = '0;
    fifo_read    = 1'b0;
    fifo_rempty  = 1'b0;
    underrun_clr = 1'b0;
    model_reset();
    #12;
    chk("rst_front", front_base, 32'd0);
    chk("rst_back", back_base, FB1);
    chk("rst_ack", swap_ack, 1'b0);
    chk("rst_pend", swap_pending, 1'b0);
    chk("rst_frame", frame_cnt, 4'd0);
    pixel_rst = 1'b0;

    repeat (3 * FRAME) tick();
    chk("idle_front", front_base, 32'd0);
    chk("idle_back", back_base, FB1);
    chk("idle_frames", frame_cnt, 4'd3);
    chk("idle_noack", acks, 0);

    repeat (10) tick();
    swap_req  = 1'b1;
    swap_base = 32'h0030_0000;
    tick();
    chk("pend_mid", swap_pending, 1'b1);
    wait_ack(2 * FRAME, n);
    chk("flip1_front", front_base, 32'h0030_0000);
    chk("flip1_back", back_base, 32'd0);
    swap_req = 1'b0;
    tick();
    chk("ack_one_cycle", swap_ack, 1'b0);

    while (pos != FRAME - 3) tick();
    swap_req  = 1'b1;
    swap_base = 32'h0040_0000;
    wait_ack(2 * FRAME + 2, n);
    chk("lat_same_edge", n, FRAME + 1);
    swap_req = 1'b0;
    tick();

    repeat (5) tick();
    swap_req  = 1'b1;
    swap_base = 32'h0030_003f;
    wait_ack(2 * FRAME, n);
    chk("align_front", front_base, 32'h0030_0000);
    swap_req = 1'b0;
    tick();

    a0        = acks;
    swap_req  = 1'b1;
    swap_base = 32'h0050_0000;
    repeat (3 * FRAME) tick();
    chk("held_one_ack", acks - a0, 1);
    swap_req = 1'b0;
    tick();
    swap_req  = 1'b1;
    swap_base = 32'h0;
    wait_ack(2 * FRAME, n);
    chk("reflip_front", front_base, 32'h0);
    chk("reflip_back", back_base, 32'h0050_0000);
    swap_req = 1'b0;
    tick();

    while (pos != FRAME - 4) tick();
    swap_req  = 1'b1;
    swap_base = 32'h0060_0000;
    wait_ack(2 * FRAME, n);
    chk("min_latency", n, 2);
    swap_req = 1'b0;
    tick();

    repeat (7) tick();
    a0        = acks;
    swap_req  = 1'b1;
    swap_base = 32'h0070_0000;
    tick();
    chk("pend_before_rst", swap_pending, 1'b1);
    #2;
    pixel_rst = 1'b1;
    #1;
    chk("mrst_front", front_base, 32'd0);
    chk("mrst_back", back_base, FB1);
    chk("mrst_pend", swap_pending, 1'b0);
    chk("mrst_frame", frame_cnt, 4'd0);
    model_reset();
    swap_req = 1'b0;
    repeat (2) tick();
    pixel_rst = 1'b0;
    repeat (FRAME + 5) tick();
    chk("rst_discard", acks - a0, 0);

    f0 = m_frame;
    repeat (16 * FRAME) tick();
    chk("frame_wrap", frame_cnt, f0);

    fifo_read   = 1'b1;
    fifo_rempty = 1'b1;
    repeat (5) tick();
`ifdef FB_SWAP_UNDERRUN_EN
    chk("urun_cnt5", underrun_cnt, 4'd5);
    chk("urun_flag", underrun_flag, 1'b1);
`else
    chk("urun_off_cnt", underrun_cnt, 4'd0);
    chk("urun_off_flag", underrun_flag, 1'b0);
`endif
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk("urun_clr_cnt", underrun_cnt, 4'd0);
    chk("urun_clr_flag", underrun_flag, 1'b0);
    repeat (20) tick();
`ifdef FB_SWAP_UNDERRUN_EN
    chk("urun_sat", underrun_cnt, 4'hf);
`else
    chk("urun_off_sat", underrun_cnt, 4'd0);
`endif
    fifo_rempty = 1'b0;
    repeat (3) tick();
    fifo_read = 1'b0;

    chk("sb_drained", sbq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
